// File: rtl/io_button_port_if.sv
// ---------------------------------------------------------------------------
// io_button_port_if
// CPU-side I/O bus between the data-memory address decoder (master) and the
// button/switch/LED port (slave).
//   p_read   : I/O read strobe (I/O address and a load in progress)
//   p_write  : I/O write strobe
//   addr     : word select, data_addr[3:2]
//   p_wdata  : store data
//   p_rdata  : read data, combinational, zero when p_read is low
// ---------------------------------------------------------------------------
interface io_button_port_if;
  logic        p_read;
  logic        p_write;
  logic [1:0]  addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;

  modport master (
    output p_read,
    output p_write,
    output addr,
    output p_wdata,
    input  p_rdata
  );

  modport slave (
    input  p_read,
    input  p_write,
    input  addr,
    input  p_wdata,
    output p_rdata
  );
endinterface

// File: rtl/io_button_port.sv
// ---------------------------------------------------------------------------
// io_button_port
// Memory-mapped I/O port: switch snapshot on buttonL, LED hand-off
// acknowledged by buttonR, 12-bit LED register for the display mux.
//
// Optional feature macro: IO_DEBOUNCE_EN
//   defined   : each synchronized button passes a DEBOUNCE_CYCLES debouncer
//   undefined : conditioned level is the synchronized level
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : CPU I/O bus (slave side)
//   button_l : raw snapshot button (async)
//   button_r : raw LED-acknowledge button (async)
//   switch   : raw switches (async)
//   led      : LED register
//   status   : {sw_ready, led_ready}
//
// Register map (bus.addr)
//   0 : status   RO {30'b0, sw_ready, led_ready}
//   1 : sw_snap  RO {16'b0, sw_snap}, read clears sw_ready
//   2 : led      RW {20'b0, led}, write clears led_ready
//   3 : reserved, reads 0, writes ignored
// ---------------------------------------------------------------------------
module io_button_port #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  io_button_port_if.slave    bus,
  input  logic               button_l,
  input  logic               button_r,
  input  logic [15:0]        switch,
  output logic [11:0]        led,
  output logic [1:0]         status
);

  // Button vectors: bit 0 = L, bit 1 = R
  logic [1:0]  r_btn_s1;
  logic [1:0]  r_btn_s2;
  logic [15:0] r_sw_s1;
  logic [15:0] r_sw_s2;
  logic [1:0]  r_lvl_d;
  logic [1:0]  w_lvl;
  logic [1:0]  w_press;

  logic [15:0] r_sw_snap;
  logic [11:0] r_led;
  logic        r_sw_ready;
  logic        r_led_ready;

  logic        w_rd_snap;
  logic        w_wr_led;

  // Only the low 12 bits of store data reach the LED register.
  logic [19:0] w_unused_wdata;
  assign w_unused_wdata = bus.p_wdata[31:12];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= {button_r, button_l};
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= switch;
      r_sw_s2  <= r_sw_s1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]    r_lvl;
  logic [CW-1:0] r_cnt [2];

  // Counter only advances while the synchronized level disagrees with the
  // accepted level; any agreement restarts the qualification window, so
  // glitches shorter than DEBOUNCE_CYCLES never flip the level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl <= '0;
      for (int b = 0; b < 2; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (r_btn_s2[b] == r_lvl[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_lvl[b] <= r_btn_s2[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_lvl = r_lvl;
`else
  logic [31:0] w_unused_deb_cycles;
  assign w_unused_deb_cycles = 32'(DEBOUNCE_CYCLES);

  assign w_lvl = r_btn_s2;
`endif

  // Rising edge of the conditioned level; release edges are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lvl_d <= '0;
    else      r_lvl_d <= w_lvl;
  end

  assign w_press  = w_lvl & ~r_lvl_d;
  assign w_rd_snap = bus.p_read  && (bus.addr == 2'd1);
  assign w_wr_led  = bus.p_write && (bus.addr == 2'd2);

  // A press in the same cycle as the clearing access keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_snap   <= '0;
      r_led       <= '0;
      r_sw_ready  <= 1'b0;
      r_led_ready <= 1'b0;
    end else begin
      if (w_press[0])     r_sw_snap <= r_sw_s2;
      if (w_wr_led)       r_led     <= bus.p_wdata[11:0];

      if (w_press[0])     r_sw_ready <= 1'b1;
      else if (w_rd_snap) r_sw_ready <= 1'b0;

      if (w_press[1])     r_led_ready <= 1'b1;
      else if (w_wr_led)  r_led_ready <= 1'b0;
    end
  end

  always_comb begin
    bus.p_rdata = '0;
    if (bus.p_read) begin
      case (bus.addr)
        2'd0:    bus.p_rdata = {30'b0, r_sw_ready, r_led_ready};
        2'd1:    bus.p_rdata = {16'b0, r_sw_snap};
        2'd2:    bus.p_rdata = {20'b0, r_led};
        default: bus.p_rdata = '0;
      endcase
    end
  end

  assign led    = r_led;
  assign status = {r_sw_ready, r_led_ready};

endmodule
